multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM plus ALU and immediate decoders for the multi-cycle RV32I core.
- Sits directly upstream of the datapath and drives every mux select and write enable in it.
- Consumes instruction fields from the instruction register and the ALU Zero flag.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

Parameters:
- None. The state encoding is fixed at 4 bits; values are listed under Behaviour.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
op  input  7  Instr[6:0]
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag from the datapath
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register / OldPC enable
ResultSrc  output  2  Result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  SrcA mux: 00 = PC, 01 = OldPC, 10 = register A
ALUSrcB  output  2  SrcB mux: 00 = register B, 01 = ImmExt, 10 = constant 4
ImmSrc  output  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  output  1  register file write enable
State  output  4  current FSM state, for debug and bench observation

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and reset.
- Reset: on a rising edge with reset=1, State <= FETCH (0). While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0; the other outputs follow State. Reset asserted mid-instruction abandons that instruction with no further writes.
- Output style: Moore outputs decoded from State. The only exceptions are PCWrite (depends on Zero), ImmSrc (depends on op) and ALUControl (depends on funct3/funct7b5).
- Unlisted controls default to 0 in every state.
- State table (encoding, outputs, next state):
  - FETCH (0): AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
  - DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next by op: lw/sw -> MEMADR; R -> EXECR; I -> EXECI; jal -> JAL; beq -> BEQ; other -> see Optional Feature.
  - MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD (3): AdrSrc=1, ResultSrc=00. Next: MEMWB.
  - MEMWB (4): ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE (5): AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
  - EXECR (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB (7): ResultSrc=00, RegWrite=1. Next: FETCH.
  - EXECI (8): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
  - JAL (9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
  - BEQ (10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
  - HALT (15): all enables 0. Next: HALT. Reachable only with the optional feature.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, beq 1100011.
- PCWrite = PCUpdate | (Branch & Zero).
- Cycle counts (including FETCH): lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- ALU decoder:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, by funct3: 000 -> sub if (op[5] & funct7b5) else add; 010 -> slt; 110 -> or; 111 -> and; other -> add.
  - ALUOp 11 -> add.
- Immediate decoder (ImmSrc from op): lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised op in DECODE moves to HALT (15) and stays there until reset.
  - Adds output port IllegalInstr (1 bit), registered: 1 from the cycle State enters HALT, cleared by reset.
- Undefined:
  - An unrecognised op in DECODE returns to FETCH and acts as a 2-cycle NOP with no writes.
  - No IllegalInstr port; State never takes value 15.

Test Plan:
- lw x5,8(x1) (op=0000011) from reset -> State 0,1,2,3,4,0. IRWrite=1 only in cycle 1, RegWrite=1 only in cycle 5 with ResultSrc=01. In state 2: ALUSrcA=10, ALUSrcB=01, ImmSrc=00.
- sw (op=0100011) -> State 0,1,2,5,0. MemWrite=1 and AdrSrc=1 only in state 5; ImmSrc=01; RegWrite stays 0.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; states 0,1,6,7,0. Repeat with funct7b5=0 -> ALUControl=000. addi with Instr[30]=1 (op=0010011) -> ALUControl=000.
- beq with Zero=1 -> PCWrite=1 in BEQ. With Zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles; ImmSrc=10.
- jal (op=1101111) -> states 0,1,9,7,0. PCWrite=1 in JAL, ImmSrc=11, RegWrite=1 in ALUWB.
- Reset=1 asserted while State=3 -> next edge State=0; all write enables 0 while reset is high. Op=1111111 in DECODE -> State=15 and IllegalInstr=1 when MULTICYCLE_CTRL_ILLEGAL_TRAP_EN is defined; State=0 when undefined.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with ALU and immediate decoders.
// Optional trap on illegal opcodes: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [3:0] State
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       IllegalInstr
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic       pc_update, branch, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next state and Moore decode of the datapath controls.
  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = HALT;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        state_d   = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held so an abandoned instruction cannot commit.
  always_comb begin
    PCWrite  = (pc_update | (branch & Zero)) & ~reset;
    MemWrite = mem_write & ~reset;
    IRWrite  = ir_write & ~reset;
    RegWrite = reg_write & ~reset;
    State    = state_q;
  end

  // ALU decoder.
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoder.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb illegal_d = illegal_q | (state_d == HALT);

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign IllegalInstr = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (default or trap build).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic       IllegalInstr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .RegWrite   (RegWrite),
    .State      (State)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    .IllegalInstr (IllegalInstr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    step();
    chk("rst_state", State, 4'd0);
    chk("rst_pcwrite", {3'b0, PCWrite}, 4'd0);
    chk("rst_irwrite", {3'b0, IRWrite}, 4'd0);
    chk("rst_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("rst_alusrcb", {2'b0, ALUSrcB}, 4'd2);
    reset = 1'b0;
    #1;
    // lw: 0,1,2,3,4,0
    chk("lw_f_irwrite", {3'b0, IRWrite}, 4'd1);
    chk("lw_f_pcwrite", {3'b0, PCWrite}, 4'd1);
    chk("lw_f_resultsrc", {2'b0, ResultSrc}, 4'd2);
    chk("lw_f_adrsrc", {3'b0, AdrSrc}, 4'd0);
    step();
    chk("lw_d_state", State, 4'd1);
    chk("lw_d_irwrite", {3'b0, IRWrite}, 4'd0);
    chk("lw_d_alusrca", {2'b0, ALUSrcA}, 4'd1);
    chk("lw_d_alusrcb", {2'b0, ALUSrcB}, 4'd1);
    step();
    chk("lw_ma_state", State, 4'd2);
    chk("lw_ma_alusrca", {2'b0, ALUSrcA}, 4'd2);
    chk("lw_ma_alusrcb", {2'b0, ALUSrcB}, 4'd1);
    chk("lw_ma_immsrc", {2'b0, ImmSrc}, 4'd0);
    chk("lw_ma_aluctl", {1'b0, ALUControl}, 4'd0);
    step();
    chk("lw_mr_state", State, 4'd3);
    chk("lw_mr_adrsrc", {3'b0, AdrSrc}, 4'd1);
    chk("lw_mr_regwrite", {3'b0, RegWrite}, 4'd0);
    step();
    chk("lw_wb_state", State, 4'd4);
    chk("lw_wb_regwrite", {3'b0, RegWrite}, 4'd1);
    chk("lw_wb_resultsrc", {2'b0, ResultSrc}, 4'd1);
    op = 7'b0100011;
    step();
    chk("lw_end_state", State, 4'd0);
    // sw: 0,1,2,5,0
    chk("sw_immsrc", {2'b0, ImmSrc}, 4'd1);
    step();
    chk("sw_d_state", State, 4'd1);
    step();
    chk("sw_ma_state", State, 4'd2);
    chk("sw_ma_memwrite", {3'b0, MemWrite}, 4'd0);
    step();
    chk("sw_mw_state", State, 4'd5);
    chk("sw_mw_memwrite", {3'b0, MemWrite}, 4'd1);
    chk("sw_mw_adrsrc", {3'b0, AdrSrc}, 4'd1);
    chk("sw_mw_regwrite", {3'b0, RegWrite}, 4'd0);
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    step();
    chk("sw_end_state", State, 4'd0);
    chk("sw_end_memwrite", {3'b0, MemWrite}, 4'd0);
    // R-type sub then funct3 sweep while in EXECR
    step();
    chk("r_d_state", State, 4'd1);
    step();
    chk("r_ex_state", State, 4'd6);
    chk("r_sub_aluctl", {1'b0, ALUControl}, 4'd1);
    chk("r_ex_alusrcb", {2'b0, ALUSrcB}, 4'd0);
    funct3 = 3'b111; #1;
    chk("r_and_aluctl", {1'b0, ALUControl}, 4'd2);
    funct3 = 3'b110; #1;
    chk("r_or_aluctl", {1'b0, ALUControl}, 4'd3);
    funct3 = 3'b010; #1;
    chk("r_slt_aluctl", {1'b0, ALUControl}, 4'd5);
    funct3 = 3'b000; funct7b5 = 1'b0; #1;
    chk("r_add_aluctl", {1'b0, ALUControl}, 4'd0);
    step();
    chk("r_wb_state", State, 4'd7);
    chk("r_wb_regwrite", {3'b0, RegWrite}, 4'd1);
    chk("r_wb_resultsrc", {2'b0, ResultSrc}, 4'd0);
    op = 7'b0010011; funct7b5 = 1'b1;
    step();
    chk("r_end_state", State, 4'd0);
    // addi with Instr[30]=1 must still add
    step();
    step();
    chk("i_ex_state", State, 4'd8);
    chk("i_addi_aluctl", {1'b0, ALUControl}, 4'd0);
    chk("i_ex_alusrcb", {2'b0, ALUSrcB}, 4'd1);
    step();
    chk("i_wb_state", State, 4'd7);
    op = 7'b1100011; funct7b5 = 1'b0; Zero = 1'b1;
    step();
    chk("i_end_state", State, 4'd0);
    // beq taken
    step();
    chk("beq_d_pcwrite", {3'b0, PCWrite}, 4'd0);
    step();
    chk("beq1_state", State, 4'd10);
    chk("beq1_pcwrite", {3'b0, PCWrite}, 4'd1);
    chk("beq1_immsrc", {2'b0, ImmSrc}, 4'd2);
    chk("beq1_aluctl", {1'b0, ALUControl}, 4'd1);
    step();
    chk("beq1_end_state", State, 4'd0);
    // beq not taken
    Zero = 1'b0;
    step();
    step();
    chk("beq0_state", State, 4'd10);
    chk("beq0_pcwrite", {3'b0, PCWrite}, 4'd0);
    op = 7'b1101111;
    step();
    chk("beq0_end_state", State, 4'd0);
    // jal: 0,1,9,7,0
    step();
    step();
    chk("jal_state", State, 4'd9);
    chk("jal_pcwrite", {3'b0, PCWrite}, 4'd1);
    chk("jal_immsrc", {2'b0, ImmSrc}, 4'd3);
    chk("jal_alusrca", {2'b0, ALUSrcA}, 4'd1);
    step();
    chk("jal_wb_state", State, 4'd7);
    chk("jal_wb_regwrite", {3'b0, RegWrite}, 4'd1);
    op = 7'b0000011;
    step();
    chk("jal_end_state", State, 4'd0);
    // reset in MEMREAD abandons the load
    step();
    step();
    step();
    chk("mr_state", State, 4'd3);
    reset = 1'b1;
    step();
    chk("rst_mid_state", State, 4'd0);
    chk("rst_mid_irwrite", {3'b0, IRWrite}, 4'd0);
    chk("rst_mid_pcwrite", {3'b0, PCWrite}, 4'd0);
    chk("rst_mid_regwrite", {3'b0, RegWrite}, 4'd0);
    step();
    chk("rst_hold_state", State, 4'd0);
    op = 7'b1111111;
    reset = 1'b0;
    // unrecognised opcode
    step();
    chk("ill_d_state", State, 4'd1);
    chk("ill_d_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("ill_d_memwrite", {3'b0, MemWrite}, 4'd0);
    step();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    chk("ill_halt_state", State, 4'd15);
    chk("ill_flag", {3'b0, IllegalInstr}, 4'd1);
    chk("ill_halt_pcwrite", {3'b0, PCWrite}, 4'd0);
    op = 7'b0000011;
    step();
    chk("ill_halt_stay", State, 4'd15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ill_rst_state", State, 4'd0);
    chk("ill_rst_flag", {3'b0, IllegalInstr}, 4'd0);
`else
    chk("ill_nop_state", State, 4'd0);
    chk("ill_nop_irwrite", {3'b0, IRWrite}, 4'd1);
    step();
    chk("ill_nop_d_state", State, 4'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
